// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_e     : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   - KEY_STAR/KEY_HASH/KEY_D : codes for the non-digit keys on row 3
//   - key_code()  : maps a (row, column) position to its 4-bit key code
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  // Keypad layout:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_tick_div.sv
// -----------------------------------------------------------------------------
// keypad_tick_div
// Free-running divider that asserts tick_o for one cycle on the last cycle of
// every SCAN_DIV-cycle period.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset (counter restarts at 0)
//   tick_o : one-cycle pulse, high while the counter holds SCAN_DIV-1
// -----------------------------------------------------------------------------
module keypad_tick_div #(
  parameter int SCAN_DIV = 27000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero after the last cycle of the period
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_encoder
// Scans a 4x4 active-low matrix keypad one column at a time and reports one
// debounced key per press.
// Ports:
//   clk      : system clock (27 MHz nominal)
//   rst      : synchronous, active-high reset
//   filas    : keypad rows, active-low, asynchronous to clk
//   columnas : column drive, active-low, exactly one column low
//   boton    : code of the last accepted key (kept after release)
//   ctrl     : high while the accepted key is held
// Parameters:
//   SCAN_DIV     : cycles per column step (>= 4)
//   DEBOUNCE_CNT : consecutive matching ticks needed for press and release (>= 2)
// -----------------------------------------------------------------------------
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 27000,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] boton,
  output logic       ctrl
);

  // Counters only ever hold 0..DEBOUNCE_CNT-1: the tick that would make the
  // count equal DEBOUNCE_CNT performs the transition instead of storing it.
  localparam int            DW       = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [3:0]    COL_RST  = 4'b1110;

  logic          tick_s;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  state_e        state_q,   state_d;
  logic [3:0]    col_q,     col_d;
  logic [1:0]    row_q,     row_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    boton_q,   boton_d;
  logic          ctrl_q,    ctrl_d;

  logic          samp_valid_s;
  logic [1:0]    samp_row_s;
  logic          all_high_s;
  logic [1:0]    col_idx_s;
  logic [3:0]    col_rot_s;

  keypad_tick_div #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick_s)
  );

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= filas;
      sync2_q <= sync1_q;
    end
  end

  // Row decode: a sample is valid only with exactly one row pulled low
  always_comb begin
    samp_valid_s = 1'b0;
    samp_row_s   = 2'd0;
    case (sync2_q)
      4'b1110: begin samp_valid_s = 1'b1; samp_row_s = 2'd0; end
      4'b1101: begin samp_valid_s = 1'b1; samp_row_s = 2'd1; end
      4'b1011: begin samp_valid_s = 1'b1; samp_row_s = 2'd2; end
      4'b0111: begin samp_valid_s = 1'b1; samp_row_s = 2'd3; end
      default: begin samp_valid_s = 1'b0; samp_row_s = 2'd0; end
    endcase
  end

  // Column decode: index of the driven (low) column
  always_comb begin
    col_idx_s = 2'd0;
    case (col_q)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
  end

  assign all_high_s = (sync2_q == 4'hF);
  // Rotate the one-cold drive: c0 -> c1 -> c2 -> c3 -> c0
  assign col_rot_s  = {col_q[2:0], col_q[3]};

  // Scanner FSM next-state and datapath logic, evaluated only on ticks
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    boton_d   = boton_q;
    ctrl_d    = ctrl_q;
    case (state_q)
      ST_SCAN: begin
        if (tick_s) begin
          if (samp_valid_s) begin
            // Column stays put so the same key is resampled
            row_d     = samp_row_s;
            deb_cnt_d = DEB_ONE;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_rot_s;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DEBOUNCE: begin
        if (tick_s) begin
          if (samp_valid_s && (samp_row_s == row_q)) begin
            if (deb_cnt_q == DEB_LAST) begin
              boton_d   = key_code(row_q, col_idx_s);
              ctrl_d    = 1'b1;
              deb_cnt_d = '0;
              rel_cnt_d = '0;
              state_d   = ST_HELD;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
          end else begin
            col_d     = col_rot_s;
            deb_cnt_d = '0;
            state_d   = ST_SCAN;
          end
        end else begin
          state_d = ST_DEBOUNCE;
        end
      end
      ST_HELD: begin
        if (tick_s) begin
          if (all_high_s) begin
            if (rel_cnt_q == DEB_LAST) begin
              ctrl_d    = 1'b0;
              col_d     = col_rot_s;
              rel_cnt_d = '0;
              state_d   = ST_SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + DEB_ONE;
            end
          end else begin
            // Any low row, even a different or multiple one, restarts release
            rel_cnt_d = '0;
          end
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d   = ST_SCAN;
        col_d     = COL_RST;
        deb_cnt_d = '0;
        rel_cnt_d = '0;
        ctrl_d    = 1'b0;
      end
    endcase
  end

  // FSM, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      col_q     <= COL_RST;
      row_q     <= 2'd0;
      deb_cnt_q <= '0;
      rel_cnt_q <= '0;
      boton_q   <= 4'h0;
      ctrl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      deb_cnt_q <= deb_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      boton_q   <= boton_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign columnas = col_q;
  assign boton    = boton_q;
  assign ctrl     = ctrl_q;

endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

Scans a 4x4 matrix keypad and produces a debounced 4-bit key code with a level "key held" flag. It drives the keypad columns one at a time, samples the rows, and presents one stable key per press on `boton`/`ctrl`. Those two outputs are consumed by the calculator top level, which performs its own rising-edge detection on `ctrl`.

## Interface
- `SCAN_DIV`, default 27000: clock cycles per column step (1 ms at 27 MHz). Must be ≥ 4.
- `DEBOUNCE_CNT`, default 16: number of consecutive matching samples required to accept a press, and also to accept a release. Must be ≥ 2.
- `clk`  in  1  system clock, 27 MHz.
- `rst`  in  1  reset, synchronous and active-high.
- `filas`  in  4  keypad rows, active-low; externally pulled up; asynchronous to `clk`.
- `columnas`  out  4  column drive, active-low, one-cold.
- `boton`  out  4  code of the accepted key. Holds its value after release.
- `ctrl`  out  1  high while an accepted key is held.

## Operation
- `filas` passes through a 2-flop synchronizer before any use.
- A tick fires on the last cycle of every `SCAN_DIV`-cycle period. Rows are sampled only on a tick, so the drive has had `SCAN_DIV - 1` cycles to settle.
- A sample is **valid** when exactly one synchronized row is low. Zero rows low, or two or more rows low, counts as no key.
- Key map, indexed as (row r, column c):
  - r0: `1` `2` `3` `A`
  - r1: `4` `5` `6` `B`
  - r2: `7` `8` `9` `C`
  - r3: `*` `0` `#` `D`
- Codes:
  - digits → BCD value
  - `A`/`B`/`C` → 4'hA / 4'hB / 4'hC
  - `*` → 4'hD
  - `#` → 4'hE
  - `D` → 4'hF
- State SCAN:
  - On a tick with no valid sample: rotate `columnas` to the next column, order c0 → c1 → c2 → c3 → c0.
  - On a tick with a valid sample: latch the row, set the count to 1, go to DEBOUNCE. The column is not rotated.
- State DEBOUNCE:
  - The column is frozen.
  - Each tick with a valid sample on the same row increments the count.
  - When the count reaches `DEBOUNCE_CNT`: load `boton` with the mapped code, set `ctrl` = 1, go to HELD.
  - A tick with any other sample: rotate the column and return to SCAN. `ctrl` stays 0 and `boton` is unchanged.
- State HELD:
  - The column is frozen and `ctrl` = 1.
  - Each tick where all rows are high increments a release count.
  - A tick with any row low clears the release count. This includes a different row or multiple rows; no new key is accepted while in HELD.
  - When the release count reaches `DEBOUNCE_CNT`: `ctrl` = 0, rotate the column, go to SCAN.
- Reset values:
  - `columnas` = 4'b1110
  - `ctrl` = 0
  - `boton` = 4'h0
  - state = SCAN
  - all counters = 0
  - synchronizer flops = 4'hF
- Reset mid-operation: `rst` sampled high in any state forces all reset values on the next edge. `ctrl` drops even if a key is still held.

## Timing
- `columnas`, `boton` and `ctrl` are all registered outputs.
- Column dwell in SCAN is exactly `SCAN_DIV` cycles.
- Press latency: `ctrl` rises and `boton` updates together, one cycle after the `DEBOUNCE_CNT`-th consecutive valid tick. The first detecting tick counts as 1.
- Row-to-sample delay is 2 cycles through the synchronizer. A row change less than 2 cycles before a tick is seen on the following tick.
- Release latency: `ctrl` falls one cycle after the `DEBOUNCE_CNT`-th consecutive all-high tick. The column rotates on that same edge.
- Minimum `ctrl` high time is `DEBOUNCE_CNT` ticks.
- `ctrl` never toggles more than once per tick.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD)
  - constants KEY_STAR = 4'hD, KEY_HASH = 4'hE, KEY_D = 4'hF
  - a function mapping (row, col) to the 4-bit code
- One sub-module, `keypad_tick_div`: a parameterized `SCAN_DIV` counter producing the one-cycle tick. It uses the same synchronous active-high `rst`.
- The synchronizer, FSM, counters and column register live in `keypad_scan_encoder`.

## Test plan
All scenarios use `SCAN_DIV` = 4 and `DEBOUNCE_CNT` = 3.
- **Reset and idle scan:** hold `rst` 2 cycles, `filas` = 4'hF → `ctrl` = 0, `boton` = 0; `columnas` steps 1110 → 1101 → 1011 → 0111 → 1110, 4 cycles per step.
- **Press `5`:** drive `filas[1]` low while `columnas` = 1101 → `columnas` freezes at 1101; `ctrl` rises with `boton` = 4'h5 one cycle after the 3rd valid tick.
- **Bounce rejection:** `filas[2]` low for one tick only → `ctrl` stays 0; `boton` unchanged; scan resumes at the next column.
- **Special-key codes:** press `*` (r3,c0), `#` (r3,c2) and `D` (r3,c3) in turn, each released fully → `boton` = 4'hD, 4'hE, 4'hF.
- **Release with a glitch:** from HELD on `5`, rows go high, glitch low on the 2nd tick, then stay high → `ctrl` falls only after 3 consecutive all-high ticks after the glitch; `boton` stays 4'h5; `columnas` moves to 1011.
- **Invalid samples and reset:**
  - `filas[0]` and `filas[3]` low in the same column → `ctrl` never rises.
  - `rst` pulsed while in HELD → the next cycle shows `ctrl` = 0, `boton` = 0, `columnas` = 1110.
